// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory port arbiter: state and owner
// encodings, geometry constants and big-endian byte-lane helpers.
package im_pkg;

    localparam int IM_ADDR_W     = 13;
    localparam int IM_WORD_BYTES = 4;
    localparam logic [1:0] IM_LAST_BYTE = 2'(IM_WORD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DEBUG = 1'b1
    } owner_e;

    // Byte idx 0 is the most significant lane (big-endian from the base address).
    function automatic logic [7:0] word_lane(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            2'd3:    return w[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] put_lane(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            2'd3:    r[7:0]   = b;
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/im_rr_arb2.sv
// Two-way round-robin grant between fetch and debug; the last-grant flag is
// registered and only moves when a grant is actually issued.
module im_rr_arb2
    import im_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_f,
    input  logic req_d,
    output logic gnt,
    output logic owner
);

    owner_e last_r;
    owner_e owner_s;
    logic   gnt_s;

    // Pick the winner; on a tie the requester not granted last wins.
    always_comb begin
        gnt_s   = en & (req_f | req_d);
        owner_s = FETCH;
        if (req_f && req_d) begin
            owner_s = (last_r == DEBUG) ? FETCH : DEBUG;
        end else if (req_d) begin
            owner_s = DEBUG;
        end else begin
            owner_s = FETCH;
        end
    end

    // Remember who was granted last; resets to debug so fetch wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= DEBUG;
        end else if (gnt_s) begin
            last_r <= owner_s;
        end else begin
            last_r <= last_r;
        end
    end

    assign gnt   = gnt_s;
    assign owner = owner_s;

endmodule

// File: rtl/im_port_arbiter.sv
// Shares the byte-wide instruction-memory port between fetch and debug, moving one
// big-endian word in four byte cycles. Debug writes exist only with IM_ARB_DBG_WRITE_EN.
module im_port_arbiter
    import im_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [31:0]       f_rdata,
    output logic              f_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_e            state_r;
    owner_e            owner_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [1:0]        cnt_r;
    logic [31:0]       f_rdata_r, d_rdata_r;
    logic              f_done_r, d_done_r, busy_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_we_r;
    logic [7:0]        mem_wdata_r;

    logic              gnt_s, gnt_owner_s;
    logic              d_we_s, gnt_we_s;
    logic [31:0]       d_wdata_s;
    logic [ADDR_W-1:0] gnt_addr_s;
    logic [1:0]        cnt_nx_s;

`ifdef IM_ARB_DBG_WRITE_EN
    assign d_we_s    = d_we;
    assign d_wdata_s = d_wdata;
`else
    logic unused_dbg_s;
    assign unused_dbg_s = ^{d_we, d_wdata};
    assign d_we_s    = 1'b0;
    assign d_wdata_s = 32'h0000_0000;
`endif

    im_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_r == IDLE),
        .req_f (f_req),
        .req_d (d_req),
        .gnt   (gnt_s),
        .owner (gnt_owner_s)
    );

    assign gnt_addr_s = (gnt_owner_s == DEBUG) ? d_addr : f_addr;
    assign gnt_we_s   = (gnt_owner_s == DEBUG) & d_we_s;
    assign cnt_nx_s   = cnt_r + 2'd1;

    // Transaction sequencer; memory strobes are set up one edge ahead so they are
    // valid during the ACCESS cycle that uses them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            owner_r     <= FETCH;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            cnt_r       <= 2'd0;
            f_rdata_r   <= 32'h0000_0000;
            d_rdata_r   <= 32'h0000_0000;
            f_done_r    <= 1'b0;
            d_done_r    <= 1'b0;
            busy_r      <= 1'b0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    f_done_r <= 1'b0;
                    d_done_r <= 1'b0;
                    if (gnt_s) begin
                        owner_r     <= owner_e'(gnt_owner_s);
                        addr_r      <= gnt_addr_s;
                        we_r        <= gnt_we_s;
                        wdata_r     <= d_wdata_s;
                        cnt_r       <= 2'd0;
                        busy_r      <= 1'b1;
                        mem_addr_r  <= gnt_addr_s;
                        mem_we_r    <= gnt_we_s;
                        mem_wdata_r <= gnt_we_s ? word_lane(d_wdata_s, 2'd0) : 8'h00;
                        state_r     <= ACCESS;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!we_r && owner_r == FETCH) begin
                        f_rdata_r <= put_lane(f_rdata_r, cnt_r, mem_rdata);
                    end else if (!we_r) begin
                        d_rdata_r <= put_lane(d_rdata_r, cnt_r, mem_rdata);
                    end else begin
                        d_rdata_r <= d_rdata_r;
                    end
                    if (cnt_r == IM_LAST_BYTE) begin
                        mem_addr_r  <= '0;
                        mem_we_r    <= 1'b0;
                        mem_wdata_r <= 8'h00;
                        f_done_r    <= (owner_r == FETCH);
                        d_done_r    <= (owner_r == DEBUG);
                        state_r     <= DONE;
                    end else begin
                        cnt_r       <= cnt_nx_s;
                        mem_addr_r  <= addr_r + ADDR_W'(cnt_nx_s);
                        mem_wdata_r <= we_r ? word_lane(wdata_r, cnt_nx_s) : 8'h00;
                    end
                end
                DONE: begin
                    f_done_r <= 1'b0;
                    d_done_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    f_done_r <= 1'b0;
                    d_done_r <= 1'b0;
                    busy_r   <= 1'b0;
                    mem_we_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign f_rdata   = f_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign f_done    = f_done_r;
    assign d_done    = d_done_r;
    assign busy      = busy_r;
    assign mem_addr  = mem_addr_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter with a byte-array memory model; debug-write
// expectations follow IM_ARB_DBG_WRITE_EN.
module tb_im_port_arbiter;

    logic        clk, rst_n;
    logic        f_req, f_done, d_req, d_we, d_done;
    logic [12:0] f_addr, d_addr, mem_addr;
    logic [31:0] f_rdata, d_rdata, d_wdata;
    logic        mem_we, busy;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  mem [0:8191];
    int          n_checks = 0;
    int          n_pass = 0;

    logic [7:0]  obs_busy, obs_fdone, obs_ddone, obs_we;
    logic [12:0] obs_addr [8];
    logic [7:0]  obs_wd [8];
    logic [31:0] obs_frd [8];
    logic [31:0] obs_drd [8];

    im_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Cycle 0 is the cycle req is first high; requests drop at the start of cycle drop_at.
    task automatic run_txn(input logic is_dbg, input logic we, input logic [12:0] addr,
                           input logic [31:0] wdata, input int drop_at);
        @(posedge clk); #1;
        if (is_dbg) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        for (int k = 0; k < 8; k++) begin
            if (k == drop_at) begin f_req = 1'b0; d_req = 1'b0; end
            @(negedge clk);
            obs_busy[k] = busy; obs_fdone[k] = f_done; obs_ddone[k] = d_done;
            obs_we[k] = mem_we; obs_addr[k] = mem_addr; obs_wd[k] = mem_wdata;
            obs_frd[k] = f_rdata; obs_drd[k] = d_rdata;
            @(posedge clk); #1;
        end
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        f_addr = 13'h0100; d_addr = 13'h0100; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({f_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata got=%h exp=0", {f_rdata, d_rdata}); else n_pass++;
        n_checks++; if ({f_done, d_done, busy} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {f_done, d_done, busy}); else n_pass++;
        n_checks++; if ({mem_addr, mem_we, mem_wdata} !== 22'h0) $display("FAIL reset_mem got=%h exp=0", {mem_addr, mem_we, mem_wdata}); else n_pass++;
        f_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_fetch();
        run_txn(1'b0, 1'b0, 13'h0100, 32'h0, 6);
        n_checks++; if (obs_busy !== 8'b0011_1110) $display("FAIL fetch_busy got=%b exp=00111110", obs_busy); else n_pass++;
        n_checks++; if (obs_fdone !== 8'b0010_0000) $display("FAIL fetch_done got=%b exp=00100000", obs_fdone); else n_pass++;
        n_checks++; if (obs_ddone !== 8'b0) $display("FAIL fetch_ddone got=%b exp=0", obs_ddone); else n_pass++;
        n_checks++; if (obs_we !== 8'b0) $display("FAIL fetch_we got=%b exp=0", obs_we); else n_pass++;
        n_checks++; if (obs_frd[5] !== 32'h1234_5678) $display("FAIL fetch_rdata got=%h exp=12345678", obs_frd[5]); else n_pass++;
        for (int k = 1; k < 5; k++) begin
            n_checks++;
            if (obs_addr[k] !== 13'h0100 + 13'(k - 1)) $display("FAIL fetch_addr c%0d got=%h exp=%h", k, obs_addr[k], 13'h0100 + 13'(k - 1)); else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [17:0] fd, dd;
        logic [31:0] fr5, dr11;
        fd = 18'h0; dd = 18'h0; fr5 = 32'h0; dr11 = 32'h0;
        do_reset();
        f_req = 1'b1; f_addr = 13'h0100; d_req = 1'b1; d_we = 1'b0; d_addr = 13'h1FFE;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            fd[k] = f_done; dd[k] = d_done;
            if (k == 5) fr5 = f_rdata;
            if (k == 11) dr11 = d_rdata;
            @(posedge clk); #1;
        end
        f_req = 1'b0; d_req = 1'b0;
        n_checks++; if (fd !== 18'h2_0020) $display("FAIL rr_fdone got=%h exp=20020", fd); else n_pass++;
        n_checks++; if (dd !== 18'h0_0800) $display("FAIL rr_ddone got=%h exp=00800", dd); else n_pass++;
        n_checks++; if (fr5 !== 32'h1234_5678) $display("FAIL rr_frdata got=%h exp=12345678", fr5); else n_pass++;
        n_checks++; if (dr11 !== 32'h1122_3344) $display("FAIL rr_drdata got=%h exp=11223344", dr11); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rr_idle_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_dbg_write();
        logic [12:0] ea [4];
        logic [7:0]  ed [4];
        ea[0] = 13'h1FFE; ea[1] = 13'h1FFF; ea[2] = 13'h0000; ea[3] = 13'h0001;
        ed[0] = 8'hDE; ed[1] = 8'hAD; ed[2] = 8'hBE; ed[3] = 8'hEF;
        run_txn(1'b1, 1'b1, 13'h1FFE, 32'hDEAD_BEEF, 6);
        n_checks++; if (obs_ddone !== 8'b0010_0000) $display("FAIL wr_ddone got=%b exp=00100000", obs_ddone); else n_pass++;
        n_checks++; if (obs_drd[5] !== 32'h1122_3344) $display("FAIL wr_drdata got=%h exp=11223344", obs_drd[5]); else n_pass++;
`ifdef IM_ARB_DBG_WRITE_EN
        n_checks++; if (obs_we !== 8'b0001_1110) $display("FAIL wr_we got=%b exp=00011110", obs_we); else n_pass++;
        for (int k = 1; k < 5; k++) begin
            n_checks++;
            if ({obs_addr[k], obs_wd[k]} !== {ea[k-1], ed[k-1]}) $display("FAIL wr_byte c%0d got=%h/%h exp=%h/%h", k, obs_addr[k], obs_wd[k], ea[k-1], ed[k-1]); else n_pass++;
        end
        n_checks++; if ({mem[13'h1FFE], mem[13'h1FFF], mem[0], mem[1]} !== 32'hDEAD_BEEF) $display("FAIL wr_array got=%h exp=deadbeef", {mem[13'h1FFE], mem[13'h1FFF], mem[0], mem[1]}); else n_pass++;
        run_txn(1'b1, 1'b0, 13'h1FFE, 32'h0, 6);
        n_checks++; if (obs_drd[5] !== 32'hDEAD_BEEF) $display("FAIL wr_readback got=%h exp=deadbeef", obs_drd[5]); else n_pass++;
`else
        n_checks++; if (obs_we !== 8'b0) $display("FAIL ro_we got=%b exp=0", obs_we); else n_pass++;
        n_checks++; if ({obs_wd[1], obs_wd[2], obs_wd[3], obs_wd[4]} !== 32'h0) $display("FAIL ro_wdata got=%h exp=0", {obs_wd[1], obs_wd[2], obs_wd[3], obs_wd[4]}); else n_pass++;
        for (int k = 1; k < 5; k++) begin
            n_checks++;
            if (obs_addr[k] !== ea[k-1]) $display("FAIL ro_addr c%0d got=%h exp=%h", k, obs_addr[k], ea[k-1]); else n_pass++;
        end
        n_checks++; if ({mem[13'h1FFE], mem[13'h1FFF], mem[0], mem[1]} !== 32'h1122_3344) $display("FAIL ro_array got=%h exp=11223344", {mem[13'h1FFE], mem[13'h1FFF], mem[0], mem[1]}); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 13'h0200; d_wdata = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef IM_ARB_DBG_WRITE_EN
        n_checks++; if ({mem_we, mem_addr} !== {1'b1, 13'h0202}) $display("FAIL rm_pre got=%b/%h exp=1/0202", mem_we, mem_addr); else n_pass++;
`else
        n_checks++; if ({mem_we, mem_addr} !== {1'b0, 13'h0202}) $display("FAIL rm_pre got=%b/%h exp=0/0202", mem_we, mem_addr); else n_pass++;
`endif
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({mem_addr, mem_we, mem_wdata} !== 22'h0) $display("FAIL rm_mem got=%h exp=0", {mem_addr, mem_we, mem_wdata}); else n_pass++;
        n_checks++; if ({f_done, d_done, busy, f_rdata, d_rdata} !== 67'h0) $display("FAIL rm_outputs got=%h exp=0", {f_done, d_done, busy, f_rdata, d_rdata}); else n_pass++;
        d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen = seen | f_done | d_done | busy;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rm_no_done got=%b exp=0", seen); else n_pass++;
`ifdef IM_ARB_DBG_WRITE_EN
        n_checks++; if ({mem[13'h200], mem[13'h201], mem[13'h202]} !== 24'hCAFE00) $display("FAIL rm_partial got=%h exp=cafe00", {mem[13'h200], mem[13'h201], mem[13'h202]}); else n_pass++;
`else
        n_checks++; if ({mem[13'h200], mem[13'h201], mem[13'h202]} !== 24'h0) $display("FAIL rm_partial got=%h exp=000000", {mem[13'h200], mem[13'h201], mem[13'h202]}); else n_pass++;
`endif
        run_txn(1'b0, 1'b0, 13'h0100, 32'h0, 6);
        n_checks++; if (obs_fdone !== 8'b0010_0000) $display("FAIL rm_fetch_done got=%b exp=00100000", obs_fdone); else n_pass++;
        n_checks++; if (obs_frd[5] !== 32'h1234_5678) $display("FAIL rm_fetch_rdata got=%h exp=12345678", obs_frd[5]); else n_pass++;
    endtask

    task automatic test_drop();
        run_txn(1'b0, 1'b0, 13'h0301, 32'h0, 2);
        n_checks++; if (obs_fdone !== 8'b0010_0000) $display("FAIL drop_done got=%b exp=00100000", obs_fdone); else n_pass++;
        n_checks++; if (obs_busy !== 8'b0011_1110) $display("FAIL drop_busy got=%b exp=00111110", obs_busy); else n_pass++;
        n_checks++; if (obs_frd[5] !== 32'hB2C3_D4E5) $display("FAIL drop_rdata got=%h exp=b2c3d4e5", obs_frd[5]); else n_pass++;
        n_checks++; if ({obs_addr[1], obs_addr[4]} !== {13'h0301, 13'h0304}) $display("FAIL drop_addr got=%h/%h exp=0301/0304", obs_addr[1], obs_addr[4]); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h0100] = 8'h12; mem[13'h0101] = 8'h34; mem[13'h0102] = 8'h56; mem[13'h0103] = 8'h78;
        mem[13'h1FFE] = 8'h11; mem[13'h1FFF] = 8'h22; mem[13'h0000] = 8'h33; mem[13'h0001] = 8'h44;
        mem[13'h0301] = 8'hB2; mem[13'h0302] = 8'hC3; mem[13'h0303] = 8'hD4; mem[13'h0304] = 8'hE5;
        test_reset();
        test_fetch();
        test_round_robin();
        test_dbg_write();
        test_reset_mid();
        test_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
